test_status_dev: RTL and testbench
==================================

# test_status_dev

Memory-mapped end-of-test device on the single-cycle core's data-memory bus. Firmware stores expected and actual values into compare slots and writes a tohost word to end the test. A watchdog cycle counter catches hung programs. Benches then check `done`, `pass` and `fail_code` instead of probing data-memory words after a guessed cycle count.

## Interface
Parameters:
- `ADDR_BASE`, 32'h0000_1000: byte base address of the device; word-aligned.
- `NUM_SLOTS`, 4: number of expect/actual compare slots, 1..16.
- `TIMEOUT_CYCLES`, 1000: watchdog limit in cycles since reset release; must be > 0.
- `CNT_W`, 32: cycle counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `we` in 1: store strobe; full-word stores only.
- `addr` in 32: byte address from the data-memory port.
- `wdata` in 32: store data.
- `hit` out 1: combinational; `addr` falls in the device window and `addr[1:0]==0`.
- `rdata` out 32: combinational read data; 0 when `!hit` or the offset is unmapped.
- `done` out 1: test has reached a terminal state.
- `pass` out 1: terminal state is PASS.
- `timeout` out 1: terminal state is TIMEOUT.
- `fail_code` out 31: code latched on FAIL.
- `cycle_count` out CNT_W: cycles spent in RUN.
- `mismatch_count` out 8: saturating count of failed slot compares.

## Operation
Register map, as byte offsets from `ADDR_BASE`:
- 0x00 TOHOST: write-only.
- 0x04 STATUS: read-only. Bit 0 = done, bit 1 = pass, bit 2 = timeout, bits 31:3 = 0.
- 0x08 CYCLE: read-only. Returns `cycle_count`, zero-extended or truncated to 32 bits.
- 0x0C MISMATCH: read-only. Returns `mismatch_count`, zero-extended.
- 0x10+8i EXPECT_i: read/write.
- 0x14+8i ACTUAL_i: write-only; reads as 0. i < NUM_SLOTS.

State machine, states RUN / PASS / FAIL / TIMEOUT, reset state RUN:
- In RUN, `cycle_count` increments by 1 every cycle.
- A TOHOST write with `wdata[0]==0` is ignored.
- A TOHOST write with `wdata==1` and `mismatch_count==0` moves to PASS.
- A TOHOST write with `wdata==1` and `mismatch_count!=0` moves to FAIL with `fail_code = 31'h7FFF_FFFF`.
- A TOHOST write with `wdata[0]==1` and `wdata!=1` moves to FAIL with `fail_code = wdata[31:1]`.
- When `cycle_count == TIMEOUT_CYCLES-1` in RUN and no TOHOST write is present, the next state is TIMEOUT.
- TOHOST write and watchdog expiry in the same cycle: the TOHOST write wins.
- PASS, FAIL and TIMEOUT are sticky until reset. In these states `cycle_count` freezes and all writes are ignored.

Compare slots:
- An ACTUAL_i write in RUN compares `wdata` against EXPECT_i. On inequality, `mismatch_count` increments, saturating at 255.
- EXPECT_i writes update the slot in any state before terminal. Writing EXPECT_i and ACTUAL_i in the same cycle is impossible (single port).
- Writes to unmapped offsets, to read-only offsets, or with `addr[1:0]!=0` have no effect.

## Timing
- Reset (`reset_n` low at an edge) clears all state: `done`, `pass`, `timeout`, `fail_code`, `cycle_count`, `mismatch_count` = 0; EXPECT_i = 0; state = RUN.
- Reset has priority over every write.
- Asserting reset mid-test aborts it; RUN restarts with `cycle_count` = 0 after release.
- All state outputs are registered. A TOHOST write sampled at edge N shows `done=1` after edge N.
- `cycle_count` equals the number of RUN edges since reset release.
- ACTUAL compare result appears in `mismatch_count` one edge after the write.
- `hit` and `rdata` are purely combinational from `addr` and the current register state, with zero-cycle read latency to match the single-cycle datapath.

## Structure
- Package `test_status_pkg` holds:
  - state enum `ts_state_e` (RUN, PASS, FAIL, TIMEOUT);
  - offset constants `TS_OFF_TOHOST`, `TS_OFF_STATUS`, `TS_OFF_CYCLE`, `TS_OFF_MISMATCH`, `TS_OFF_SLOT0`;
  - `TS_SLOT_STRIDE = 8`;
  - `TS_FAIL_MISMATCH = 31'h7FFF_FFFF`.
- Sub-module `test_status_slot`, generated NUM_SLOTS times. It contains the EXPECT register, write-enable decode inputs and a `mismatch_pulse` output. The top ORs the pulses into the saturating counter; one write per cycle guarantees at most one pulse.

## Test plan
- Reset, write 1 to TOHOST at cycle 5 → `done=1`, `pass=1`, `cycle_count` frozen at 5, STATUS reads 0x3.
- EXPECT_0=12, ACTUAL_0=12, EXPECT_1=7, ACTUAL_1=9, then TOHOST=1 → `mismatch_count=1`, FAIL, `fail_code=31'h7FFF_FFFF`.
- TOHOST=0x0000_0007 → FAIL, `fail_code=3`. A later TOHOST=1 is ignored and the state stays FAIL.
- TIMEOUT_CYCLES=20, no writes → `timeout=1`, `done=1` after 20 edges, `cycle_count=19` frozen. Variant: TOHOST=1 on the expiry cycle → PASS.
- 300 mismatching ACTUAL writes → `mismatch_count` saturates at 255. Pulse `reset_n` low for 1 cycle → all outputs 0, state RUN.
- Unaligned store to ADDR_BASE+1 and store to an unmapped offset → `hit=0` for the unaligned address, no state change; `rdata` of an unmapped offset = 0.

Source files
------------

// File: rtl/test_status_pkg.sv
// test_status_pkg: state encoding and register map of the end-of-test device.
package test_status_pkg;
  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} ts_state_e;
  localparam logic [31:0] TS_OFF_TOHOST = 32'h00;
  localparam logic [31:0] TS_OFF_STATUS = 32'h04;
  localparam logic [31:0] TS_OFF_CYCLE = 32'h08;
  localparam logic [31:0] TS_OFF_MISMATCH = 32'h0C;
  localparam logic [31:0] TS_OFF_SLOT0 = 32'h10;
  localparam logic [31:0] TS_SLOT_STRIDE = 32'd8;
  localparam logic [30:0] TS_FAIL_MISMATCH = 31'h7FFF_FFFF;
endpackage

// File: rtl/test_status_slot.sv
// test_status_slot: one EXPECT register plus the compare against an ACTUAL store.
module test_status_slot (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exp_we,
  input  logic        act_we,
  input  logic [31:0] wdata,
  output logic [31:0] exp_val,
  output logic        mismatch_pulse
);
  always_ff @(posedge clk)
    if (!reset_n) exp_val <= '0;
    else if (exp_we) exp_val <= wdata;
  assign mismatch_pulse = act_we && wdata != exp_val;
endmodule

// File: rtl/test_status_dev.sv
// test_status_dev: memory-mapped end-of-test device with compare slots and watchdog.
module test_status_dev
  import test_status_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_1000,
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             hit,
  output logic [31:0]      rdata,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       mismatch_count
);
  localparam logic [31:0] WIN = TS_OFF_SLOT0 + TS_SLOT_STRIDE * 32'(NUM_SLOTS);
  ts_state_e state, state_n;
  logic [30:0] fail_n;
  logic [31:0] off, slot_or;
  logic [NUM_SLOTS-1:0] pulse;
  logic [31:0] slot_rd [NUM_SLOTS];
  logic wr, tohost;
  assign off = addr - ADDR_BASE;
  assign hit = off < WIN && addr[1:0] == 2'b0;
  assign wr = we && hit && state == RUN;
  assign tohost = wr && off == TS_OFF_TOHOST && wdata[0];
  assign done = state != RUN;
  assign pass = state == PASS;
  assign timeout = state == TIMEOUT;
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    localparam logic [31:0] OFF_E = TS_OFF_SLOT0 + TS_SLOT_STRIDE * 32'(g);
    logic [31:0] exp_val;
    test_status_slot u_slot (
      .clk            (clk),
      .reset_n        (reset_n),
      .exp_we         (wr && off == OFF_E),
      .act_we         (wr && off == OFF_E + 32'd4),
      .wdata          (wdata),
      .exp_val        (exp_val),
      .mismatch_pulse (pulse[g])
    );
    assign slot_rd[g] = off == OFF_E ? exp_val : '0;
  end
  always_comb begin
    slot_or = '0;
    for (int i = 0; i < NUM_SLOTS; i++) slot_or = slot_or | slot_rd[i];
    rdata = !hit ? '0 :
            off == TS_OFF_STATUS ? {29'b0, timeout, pass, done} :
            off == TS_OFF_CYCLE ? 32'(cycle_count) :
            off == TS_OFF_MISMATCH ? {24'b0, mismatch_count} : slot_or;
  end
  // An effective TOHOST write takes precedence over watchdog expiry.
  always_comb begin
    state_n = state;
    fail_n = fail_code;
    if (state == RUN) begin
      if (tohost && wdata == 32'd1) begin
        state_n = mismatch_count == 8'd0 ? PASS : FAIL;
        fail_n = mismatch_count == 8'd0 ? fail_code : TS_FAIL_MISMATCH;
      end else if (tohost) begin
        state_n = FAIL;
        fail_n = wdata[31:1];
      end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_n = TIMEOUT;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= RUN;
      fail_code <= '0;
      cycle_count <= '0;
      mismatch_count <= '0;
    end else begin
      state <= state_n;
      fail_code <= fail_n;
      if (state == RUN && state_n == RUN) cycle_count <= cycle_count + 1'b1;
      if (|pulse && mismatch_count != 8'hFF) mismatch_count <= mismatch_count + 8'd1;
    end
endmodule

// File: tb/tb_test_status_dev.sv
// tb_test_status_dev: scoreboard and table-driven checks of the end-of-test device.
module tb_test_status_dev;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 0, reset_n = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic hit, done, pass, timeout, t_hit, t_done, t_pass, t_timeout;
  logic [31:0] rdata, t_rdata, cycle_count, t_cycle_count;
  logic [30:0] fail_code, t_fail_code;
  logic [7:0] mismatch_count, t_mismatch_count;
  int checks = 0, errors = 0;

  test_status_dev dut (
    .clk(clk), .reset_n(reset_n), .we(we), .addr(addr), .wdata(wdata),
    .hit(hit), .rdata(rdata), .done(done), .pass(pass), .timeout(timeout),
    .fail_code(fail_code), .cycle_count(cycle_count), .mismatch_count(mismatch_count)
  );
  test_status_dev #(.TIMEOUT_CYCLES(20)) dut_t (
    .clk(clk), .reset_n(reset_n), .we(we), .addr(addr), .wdata(wdata),
    .hit(t_hit), .rdata(t_rdata), .done(t_done), .pass(t_pass), .timeout(t_timeout),
    .fail_code(t_fail_code), .cycle_count(t_cycle_count), .mismatch_count(t_mismatch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic d, p, t;
    logic [30:0] fc;
    logic [7:0] mc;
  } st_t;
  st_t sb[$];

  typedef struct {
    logic [31:0] off;
    logic hit;
    logic [31:0] rdata;
  } rd_vec_t;
  rd_vec_t rv[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 0;
    we = 0;
    tick;
    reset_n = 1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1;
    tick;
    we = 0;
    addr = 0;
  endtask

  task automatic push(input string n, input logic d, input logic p, input logic t,
                      input logic [30:0] fc, input logic [7:0] mc);
    st_t e;
    e.name = n; e.d = d; e.p = p; e.t = t; e.fc = fc; e.mc = mc;
    sb.push_back(e);
  endtask

  task automatic pop_chk;
    st_t e;
    e = sb.pop_front();
    chk({e.name, ".done"}, 32'(done), 32'(e.d));
    chk({e.name, ".pass"}, 32'(pass), 32'(e.p));
    chk({e.name, ".timeout"}, 32'(timeout), 32'(e.t));
    chk({e.name, ".fail_code"}, 32'(fail_code), 32'(e.fc));
    chk({e.name, ".mismatch"}, 32'(mismatch_count), 32'(e.mc));
  endtask

  initial begin
    int n;
    rv[0] = '{32'h04, 1'b1, 32'h3};
    rv[1] = '{32'h08, 1'b1, 32'd5};
    rv[2] = '{32'h0C, 1'b1, 32'd0};
    rv[3] = '{32'h00, 1'b1, 32'd0};
    rv[4] = '{32'h10, 1'b1, 32'hA5};
    rv[5] = '{32'h14, 1'b1, 32'd0};
    rv[6] = '{32'h18, 1'b1, 32'd0};
    rv[7] = '{32'h01, 1'b0, 32'd0};
    rv[8] = '{32'h30, 1'b0, 32'd0};
    rv[9] = '{32'h2C, 1'b1, 32'd0};
    rv[10] = '{32'hFFFF_FFFC, 1'b0, 32'd0};
    rv[11] = '{32'h11, 1'b0, 32'd0};

    // PASS at cycle 5, then register reads from the table
    do_reset;
    push("reset", 0, 0, 0, 0, 0);
    pop_chk;
    chk("reset.cycle", cycle_count, 0);
    wr(BASE + 32'h10, 32'hA5);
    n = 0;
    while (cycle_count != 5 && n < 50) begin
      tick;
      n++;
    end
    chk("wait_cycle5", cycle_count, 5);
    push("pass", 1, 1, 0, 0, 0);
    wr(BASE, 1);
    pop_chk;
    chk("pass.cycle", cycle_count, 5);
    wr(BASE + 32'h18, 5);
    tick;
    tick;
    chk("pass.frozen", cycle_count, 5);
    for (int i = 0; i < 12; i++) begin
      addr = BASE + rv[i].off;
      #1;
      chk($sformatf("rd%0d.hit", i), 32'(hit), 32'(rv[i].hit));
      chk($sformatf("rd%0d.rdata", i), rdata, rv[i].rdata);
    end
    addr = 0;

    // Slot compares then TOHOST=1 with a mismatch recorded
    do_reset;
    wr(BASE + 32'h10, 12);
    wr(BASE + 32'h14, 12);
    wr(BASE + 32'h18, 7);
    chk("match.mc", 32'(mismatch_count), 0);
    wr(BASE + 32'h1C, 9);
    chk("mismatch.mc", 32'(mismatch_count), 1);
    addr = BASE + 32'h0C;
    #1;
    chk("mismatch.rd", rdata, 1);
    push("mm_fail", 1, 0, 0, 31'h7FFF_FFFF, 1);
    wr(BASE, 1);
    pop_chk;

    // Even TOHOST ignored, code 3, then sticky FAIL
    do_reset;
    push("tohost_even", 0, 0, 0, 0, 0);
    wr(BASE, 2);
    pop_chk;
    push("code3", 1, 0, 0, 3, 0);
    wr(BASE, 7);
    pop_chk;
    push("sticky", 1, 0, 0, 3, 0);
    wr(BASE, 1);
    pop_chk;

    // Watchdog at 20 cycles
    do_reset;
    repeat (19) tick;
    chk("wd19.timeout", 32'(t_timeout), 0);
    chk("wd19.cycle", t_cycle_count, 19);
    tick;
    chk("wd20.timeout", 32'(t_timeout), 1);
    chk("wd20.done", 32'(t_done), 1);
    chk("wd20.pass", 32'(t_pass), 0);
    chk("wd20.cycle", t_cycle_count, 19);
    repeat (3) tick;
    chk("wd.frozen", t_cycle_count, 19);
    chk("wd.other_cycle", cycle_count, 23);
    do_reset;
    repeat (19) tick;
    wr(BASE, 1);
    chk("wd_race.pass", 32'(t_pass), 1);
    chk("wd_race.timeout", 32'(t_timeout), 0);
    chk("wd_race.done", 32'(t_done), 1);

    // Saturation and mid-test reset
    do_reset;
    wr(BASE + 32'h10, 32'h55);
    for (int i = 0; i < 300; i++) wr(BASE + 32'h14, 32'h100 + i);
    chk("sat.mc", 32'(mismatch_count), 255);
    chk("sat.done", 32'(done), 0);
    chk("sat.cycle", cycle_count, 301);
    do_reset;
    push("after_reset", 0, 0, 0, 0, 0);
    pop_chk;
    chk("after_reset.cycle", cycle_count, 0);
    addr = BASE + 32'h10;
    #1;
    chk("after_reset.exp0", rdata, 0);
    addr = 0;

    // Stores with no effect
    do_reset;
    wr(BASE + 32'h1, 1);
    wr(BASE + 32'h40, 1);
    wr(BASE + 32'h4, 1);
    wr(BASE + 32'h12, 3);
    push("no_effect", 0, 0, 0, 0, 0);
    pop_chk;
    chk("no_effect.cycle", cycle_count, 4);
    addr = BASE + 32'h10;
    #1;
    chk("no_effect.exp0", rdata, 0);
    addr = BASE + 32'h40;
    #1;
    chk("unmapped.hit", 32'(hit), 0);
    chk("unmapped.rdata", rdata, 0);
    addr = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
